// File: rtl/alu_result_serializer.sv
// Serializes the registered ALU result into the UART TX FIFO one byte at a time.
// A result that arrives while a transfer is still in progress is dropped and latched in OVR_ERR.
module alu_result_serializer #(
  parameter int ALU_WIDTH  = 16,
  parameter int DATA_WIDTH = 8,
  parameter int MSB_FIRST  = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ALU_WIDTH-1:0]  ALU_OUT,
  input  logic                  ALU_OUT_VALID,
  input  logic                  FIFO_FULL,
  output logic [DATA_WIDTH-1:0] WR_DATA,
  output logic                  WR_INC,
  output logic                  BUSY,
  output logic                  OVR_ERR,
  input  logic                  OVR_CLR
);

  localparam int NBYTES = (ALU_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int SH_W   = NBYTES * DATA_WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]            state;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      sel;
  logic [SH_W-1:0]       shadow;
  logic [DATA_WIDTH-1:0] cur_byte;
  logic                  wr_inc;
  logic                  ovr;

  // FIFO_FULL is the only input that reaches WR_INC combinationally.
  always_comb begin
    wr_inc   = (state == SEND) && !FIFO_FULL;
    sel      = (MSB_FIRST != 0) ? (LAST_IDX - idx) : idx;
    cur_byte = '0;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (sel == IDX_W'(i)) cur_byte = shadow[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign WR_INC  = wr_inc;
  assign WR_DATA = wr_inc ? cur_byte : '0;
  assign BUSY    = (state == SEND);
  assign OVR_ERR = ovr;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= IDLE;
      idx    <= '0;
      shadow <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ALU_OUT_VALID) begin
            shadow <= SH_W'(ALU_OUT);
            idx    <= '0;
            state  <= SEND;
          end
        end
        SEND: begin
          if (wr_inc) begin
            if (idx == LAST_IDX) begin
              state <= IDLE;
              idx   <= '0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

  // A new overrun outranks a clear in the same cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ovr <= 1'b0;
    end else if (ALU_OUT_VALID && (state == SEND)) begin
      ovr <= 1'b1;
    end else if (OVR_CLR) begin
      ovr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_result_serializer.sv
// Directed bench for alu_result_serializer: default 16-bit LSB-first instance
// plus a 12-bit MSB-first instance.
module tb_alu_result_serializer;

  logic        clk;
  logic        rst;

  logic [15:0] alu_out;
  logic        alu_valid;
  logic        fifo_full;
  logic        ovr_clr;
  logic [7:0]  wr_data;
  logic        wr_inc;
  logic        busy;
  logic        ovr_err;

  logic [11:0] m_alu_out;
  logic        m_valid;
  logic        m_full;
  logic        m_clr;
  logic [7:0]  m_wr_data;
  logic        m_wr_inc;
  logic        m_busy;
  logic        m_ovr_err;

  int checks   = 0;
  int failures = 0;

  alu_result_serializer dut (
    .CLK           (clk),
    .RST           (rst),
    .ALU_OUT       (alu_out),
    .ALU_OUT_VALID (alu_valid),
    .FIFO_FULL     (fifo_full),
    .WR_DATA       (wr_data),
    .WR_INC        (wr_inc),
    .BUSY          (busy),
    .OVR_ERR       (ovr_err),
    .OVR_CLR       (ovr_clr)
  );

  alu_result_serializer #(
    .ALU_WIDTH  (12),
    .DATA_WIDTH (8),
    .MSB_FIRST  (1)
  ) dut_msb (
    .CLK           (clk),
    .RST           (rst),
    .ALU_OUT       (m_alu_out),
    .ALU_OUT_VALID (m_valid),
    .FIFO_FULL     (m_full),
    .WR_DATA       (m_wr_data),
    .WR_INC        (m_wr_inc),
    .BUSY          (m_busy),
    .OVR_ERR       (m_ovr_err),
    .OVR_CLR       (m_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic inc, input logic [7:0] data,
                            input logic bsy, input logic ovr);
    check({tag, ".wr_inc"},  32'(wr_inc),  32'(inc));
    check({tag, ".wr_data"}, 32'(wr_data), 32'(data));
    check({tag, ".busy"},    32'(busy),    32'(bsy));
    check({tag, ".ovr_err"}, 32'(ovr_err), 32'(ovr));
  endtask

  task automatic expect_msb(input string tag, input logic inc, input logic [7:0] data,
                            input logic bsy);
    check({tag, ".wr_inc"},  32'(m_wr_inc),  32'(inc));
    check({tag, ".wr_data"}, 32'(m_wr_data), 32'(data));
    check({tag, ".busy"},    32'(m_busy),    32'(bsy));
  endtask

  // Each cycle: inputs change 1 time unit after the rising edge, outputs sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    alu_out = '0; alu_valid = 1'b0; fifo_full = 1'b0; ovr_clr = 1'b0;
    m_alu_out = '0; m_valid = 1'b0; m_full = 1'b0; m_clr = 1'b0;
    #3;
    expect_out("reset", 1'b0, 8'h00, 1'b0, 1'b0);
    expect_msb("reset_msb", 1'b0, 8'h00, 1'b0);
    next_cycle(); rst = 1'b1;
    next_cycle();

    // Basic LSB-first
    alu_out = 16'hA55A; alu_valid = 1'b1;
    mid(); expect_out("basic.c0", 1'b0, 8'h00, 1'b0, 1'b0);
    next_cycle(); alu_valid = 1'b0; alu_out = 16'h0000;
    mid(); expect_out("basic.c1", 1'b1, 8'h5A, 1'b1, 1'b0);
    next_cycle();
    mid(); expect_out("basic.c2", 1'b1, 8'hA5, 1'b1, 1'b0);
    next_cycle();
    mid(); expect_out("basic.c3", 1'b0, 8'h00, 1'b0, 1'b0);

    // Backpressure
    next_cycle(); alu_out = 16'h1234; alu_valid = 1'b1;
    mid();
    next_cycle(); alu_valid = 1'b0; fifo_full = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      mid(); expect_out($sformatf("bp.c%0d", c), 1'b0, 8'h00, 1'b1, 1'b0);
      if (c < 4) next_cycle();
    end
    next_cycle(); fifo_full = 1'b0;
    mid(); expect_out("bp.c5", 1'b1, 8'h34, 1'b1, 1'b0);
    next_cycle();
    mid(); expect_out("bp.c6", 1'b1, 8'h12, 1'b1, 1'b0);
    next_cycle();
    mid(); expect_out("bp.c7", 1'b0, 8'h00, 1'b0, 1'b0);

    // Overrun: second word during the last-byte cycle is dropped
    next_cycle(); alu_out = 16'h00FF; alu_valid = 1'b1;
    mid();
    next_cycle(); alu_valid = 1'b0;
    mid(); expect_out("ovr.c1", 1'b1, 8'hFF, 1'b1, 1'b0);
    next_cycle(); alu_out = 16'hBEEF; alu_valid = 1'b1;
    mid(); expect_out("ovr.c2", 1'b1, 8'h00, 1'b1, 1'b0);
    next_cycle(); alu_valid = 1'b0;
    mid(); expect_out("ovr.c3", 1'b0, 8'h00, 1'b0, 1'b1);
    next_cycle();
    mid(); expect_out("ovr.c4", 1'b0, 8'h00, 1'b0, 1'b1);
    next_cycle(); ovr_clr = 1'b1;
    mid(); expect_out("ovr.clr_cycle", 1'b0, 8'h00, 1'b0, 1'b1);
    next_cycle(); ovr_clr = 1'b0;
    mid(); expect_out("ovr.cleared", 1'b0, 8'h00, 1'b0, 1'b0);

    // Overrun and clear together: set wins, shadow unaffected
    next_cycle(); alu_out = 16'h0102; alu_valid = 1'b1;
    mid();
    next_cycle(); alu_out = 16'hDEAD; ovr_clr = 1'b1;
    mid(); expect_out("ovrclr.b0", 1'b1, 8'h02, 1'b1, 1'b0);
    next_cycle(); alu_valid = 1'b0; ovr_clr = 1'b0;
    mid(); expect_out("ovrclr.b1", 1'b1, 8'h01, 1'b1, 1'b1);
    next_cycle(); ovr_clr = 1'b1;
    mid(); expect_out("ovrclr.idle", 1'b0, 8'h00, 1'b0, 1'b1);
    next_cycle(); ovr_clr = 1'b0;
    mid(); expect_out("ovrclr.done", 1'b0, 8'h00, 1'b0, 1'b0);

    // Reset mid-transfer
    next_cycle(); alu_out = 16'h5678; alu_valid = 1'b1;
    mid();
    next_cycle(); alu_valid = 1'b0;
    mid(); expect_out("rst.b0", 1'b1, 8'h78, 1'b1, 1'b0);
    #2 rst = 1'b0;
    #1 expect_out("rst.async", 1'b0, 8'h00, 1'b0, 1'b0);
    next_cycle(); rst = 1'b1;
    mid(); expect_out("rst.after0", 1'b0, 8'h00, 1'b0, 1'b0);
    next_cycle();
    mid(); expect_out("rst.after1", 1'b0, 8'h00, 1'b0, 1'b0);
    next_cycle(); alu_out = 16'hC0DE; alu_valid = 1'b1;
    mid();
    next_cycle(); alu_valid = 1'b0;
    mid(); expect_out("rst.next_b0", 1'b1, 8'hDE, 1'b1, 1'b0);
    next_cycle();
    mid(); expect_out("rst.next_b1", 1'b1, 8'hC0, 1'b1, 1'b0);

    // Back-to-back: valid in cycles 0 and 3
    next_cycle(); alu_out = 16'h1111; alu_valid = 1'b1;
    mid();
    next_cycle(); alu_valid = 1'b0;
    mid(); expect_out("b2b.c1", 1'b1, 8'h11, 1'b1, 1'b0);
    next_cycle();
    mid(); expect_out("b2b.c2", 1'b1, 8'h11, 1'b1, 1'b0);
    next_cycle(); alu_out = 16'h2222; alu_valid = 1'b1;
    mid(); expect_out("b2b.c3", 1'b0, 8'h00, 1'b0, 1'b0);
    next_cycle(); alu_valid = 1'b0;
    mid(); expect_out("b2b.c4", 1'b1, 8'h22, 1'b1, 1'b0);
    next_cycle();
    mid(); expect_out("b2b.c5", 1'b1, 8'h22, 1'b1, 1'b0);
    next_cycle();
    mid(); expect_out("b2b.c6", 1'b0, 8'h00, 1'b0, 1'b0);

    // MSB-first, 12-bit word zero-extended to 16 bits, with one stall cycle
    next_cycle(); m_alu_out = 12'hABC; m_valid = 1'b1;
    mid(); expect_msb("msb.c0", 1'b0, 8'h00, 1'b0);
    next_cycle(); m_valid = 1'b0; m_alu_out = 12'h000;
    mid(); expect_msb("msb.c1", 1'b1, 8'h0A, 1'b1);
    next_cycle(); m_full = 1'b1;
    mid(); expect_msb("msb.stall", 1'b0, 8'h00, 1'b1);
    next_cycle(); m_full = 1'b0;
    mid(); expect_msb("msb.c3", 1'b1, 8'hBC, 1'b1);
    next_cycle();
    mid(); expect_msb("msb.c4", 1'b0, 8'h00, 1'b0);
    check("msb.ovr_err", 32'(m_ovr_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
